imm_ext_stage: RTL

IMM_EXT_STAGE -- requirements
Module: imm_ext_stage

---
 rtl/imm_ext_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/imm_ext_stage.sv
// -----------------------------------------------------------------------------
// imm_ext_stage
//
// Purpose:
//   Extracts the immediate field from a RISC-V instruction word and
//   sign/zero-extends it to XLEN bits. The decode is purely combinational on
//   the input side. Its result (immediate plus an illegal-format flag) is
//   registered in a two-entry elastic buffer. The buffer has an output stage
//   and a skid stage, so ready_o never depends combinationally on ready_i.
//   Entries leave in acceptance order.
//
// Parameters:
//   XLEN       datapath width, 32 or 64
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_i      synchronous active-high reset
//   instr_i    instruction bits [31:7] that carry the immediate fields
//   immsrc_i   immediate format select (I,S,B,J,U,Z,SH, 111 = illegal)
//   valid_i    upstream entry valid
//   ready_o    block can accept an entry this cycle
//   flush_i    discard all held and incoming entries
//   valid_o    output entry valid
//   ready_i    downstream accepts the output entry
//   immext_o   extended immediate of the output entry
//   err_o      output entry carried the illegal format code
// -----------------------------------------------------------------------------
module imm_ext_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:7]     instr_i,
    input  logic [2:0]      immsrc_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] immext_o,
    output logic            err_o
);

    // Each stored entry is {err, immediate}.
    localparam int DW = XLEN + 1;

    // Builds every format at 64 bits and then truncates to XLEN. This keeps
    // one code path for both widths and avoids zero-width replications when
    // XLEN is 32. The U format therefore gets its upper-half sign extension
    // for free when XLEN is 64.
    function automatic logic [DW-1:0] decode_imm(
        input logic [31:7] instr,
        input logic [2:0]  sel
    );
        logic [63:0] imm64;
        logic        err;
        logic        s;
        s     = instr[31];
        err   = 1'b0;
        imm64 = 64'd0;
        case (sel)
            3'b000: imm64 = {{52{s}}, instr[31:20]};
            3'b001: imm64 = {{52{s}}, instr[31:25], instr[11:7]};
            3'b010: imm64 = {{52{s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: imm64 = {{44{s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b100: imm64 = {{32{s}}, instr[31:12], 12'd0};
            3'b101: imm64 = {59'd0, instr[19:15]};
            // The shift amount is one bit wider on RV64.
            3'b110: imm64 = (XLEN == 64) ? {58'd0, instr[25:20]}
                                         : {59'd0, instr[24:20]};
            3'b111: begin
                imm64 = 64'd0;
                err   = 1'b1;
            end
            default: begin
                imm64 = 64'd0;
                err   = 1'b0;
            end
        endcase
        return {err, imm64[XLEN-1:0]};
    endfunction

    logic          out_valid_q,  out_valid_d;
    logic [DW-1:0] out_data_q,   out_data_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q,  skid_data_d;

    logic          ready_s;
    logic          accept_s;
    logic          fire_s;
    logic          out_free_s;
    logic [DW-1:0] new_data_s;

    // Handshake terms. ready depends only on the skid flag and reset, so there
    // is no combinational path from ready_i.
    always_comb begin
        ready_s    = !skid_valid_q && !rst_i;
        accept_s   = valid_i && ready_s;
        fire_s     = out_valid_q && ready_i;
        out_free_s = !out_valid_q || fire_s;
        new_data_s = decode_imm(instr_i, immsrc_i);
    end

    // Next-state logic for the output and skid stages. Flush overrides every
    // other event. A full skid stage always refills the output stage before
    // any new entry, which preserves ordering.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free_s) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_valid_d  = 1'b1;
                out_data_d   = new_data_s;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept_s) begin
            // The output stage is stalled, so the new entry parks in skid.
            skid_valid_d = 1'b1;
            skid_data_d  = new_data_s;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // Stage registers with synchronous reset that clears flags and data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    // Output drive. The data comes straight from the output stage register.
    always_comb begin
        ready_o  = ready_s;
        valid_o  = out_valid_q;
        immext_o = out_data_q[XLEN-1:0];
        err_o    = out_data_q[XLEN];
    end

endmodule
